pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have derived constant STAGES = WIDTH/CHUNK, meaning pipeline depth, which is not user-overridable.
REQ-004 The port list SHALL begin with clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The port rst SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The port in_valid SHALL be an input, 1 bit: operands and mode presented.
REQ-007 The port in_ready SHALL be an output, 1 bit: block accepts an operation this cycle.
REQ-008 The port in1 SHALL be an input, WIDTH bits: first operand.
REQ-009 The port in2 SHALL be an input, WIDTH bits: second operand.
REQ-010 The port sub SHALL be an input, 1 bit: 0 = in1+in2, 1 = in1-in2.
REQ-011 The port out_valid SHALL be an output, 1 bit: result presented.
REQ-012 The port out_ready SHALL be an input, 1 bit: downstream accepts the result.
REQ-013 The port out SHALL be an output, WIDTH bits: sum/difference.
REQ-014 The port cout SHALL be an output, 1 bit: carry out of MSB (subtract: 1 = no borrow).
REQ-015 The port ovf SHALL be an output, 1 bit: signed two's-complement overflow.
REQ-016 The port zero SHALL be an output, 1 bit: out equals zero.

Function
REQ-017 Subtract SHALL be computed as in1 + ~in2 + 1 (inverted in2, carry-in 1 into chunk 0); add SHALL use carry-in 0.
REQ-018 Stage k (0..STAGES-1) SHALL add chunk k of both operands plus the registered carry from stage k-1; upper operand chunks and lower result chunks SHALL be skew-delayed so out is aligned.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted input (in_valid && in_ready) to out_valid, with no stall.
REQ-020 Pipeline advance enable SHALL be (!out_valid || out_ready); in_ready SHALL equal this enable combinationally.
REQ-021 When enable is low, all stage registers, valid bits and outputs SHALL hold; no operation is dropped or duplicated.
REQ-022 When enable is high and in_valid is low, a bubble (valid=0) SHALL enter stage 0; bubbles are not compressed.
REQ-023 Throughput SHALL be one operation per cycle with out_ready held high; results SHALL leave in acceptance order.
REQ-024 cout SHALL be the carry out of the final stage; out, cout, ovf and zero SHALL be registered and stable while out_valid && !out_ready.
REQ-025 When STAGES = 1 the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-026 On rst low, all valid bits, out, cout, ovf and zero SHALL go to 0 immediately; in-flight operations are discarded.
REQ-027 in_ready SHALL read 1 during and after reset; the first out_valid after reset release SHALL be for an operation accepted after release.

Configuration
REQ-028 Macro PIPE_ADDER_FLAGS_EN defined: ovf = (in1[MSB] == effective in2[MSB]) && (out[MSB] != in1[MSB]), zero = (out == 0), both aligned with out.
REQ-029 Macro PIPE_ADDER_FLAGS_EN undefined: ovf and zero SHALL be constant 0 and their logic and delay registers SHALL not exist; ports remain.

Structure
REQ-030 Package pipe_adder_pkg SHALL hold default WIDTH/CHUNK constants and the mode encoding (ADD=0, SUB=1).
REQ-031 One sub-module adder_slice (CHUNK-bit a, b, cin -> sum, cout, combinational) SHALL be instantiated once per stage.

Verification (WIDTH=32, CHUNK=8, flags enabled)
REQ-032 add 0xFFFFFFFF + 0x00000001 -> after 4 cycles out=0x00000000, cout=1, zero=1, ovf=0.
REQ-033 sub 5 - 7 -> out=0xFFFFFFFE, cout=0, ovf=0, zero=0; sub 7 - 5 -> out=2, cout=1.
REQ-034 add 0x7FFFFFFF + 1 -> out=0x80000000, ovf=1; sub 0x80000000 - 1 -> out=0x7FFFFFFF, ovf=1.
REQ-035 Six back-to-back ops, out_ready low for 3 cycles mid-stream -> in_ready low same cycles, all six results in order, none lost.
REQ-036 rst low for 1 cycle with 2 ops in flight -> out_valid=0 at once; next result seen is the first op issued after release.
REQ-037 Rebuild without PIPE_ADDER_FLAGS_EN, repeat REQ-034 -> out identical, ovf=0, zero=0.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants and mode encoding for the chunked pipelined adder.
// The signed-overflow helper is used only when PIPE_ADDER_FLAGS_EN is defined.
`timescale 1ns/1ps
package pipe_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Overflow when the operands share a sign and the result sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
`timescale 1ns/1ps
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] w_total;

    assign w_total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum     = w_total[CHUNK-1:0];
    assign cout    = w_total[CHUNK];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, CHUNK bits per stage, valid/ready flow control.
// Optional macro PIPE_ADDER_FLAGS_EN enables the registered ovf and zero flags.
`timescale 1ns/1ps
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int CHUNK  = DEF_CHUNK,
    localparam int STAGES = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_b_eff  = (mode_e'(sub) == MODE_SUB) ? ~in2 : in2;

    // Stage k consumes the lowest remaining operand chunk; only the untouched
    // upper operand bits travel forward while the result grows from the bottom.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * CHUNK;
        localparam int OPW = WIDTH - LO;

        logic [OPW-1:0]      w_a_in;
        logic [OPW-1:0]      w_b_in;
        logic                w_c_in;
        logic                w_v_in;
        logic [CHUNK-1:0]    w_s;
        logic                w_co;
        logic [LO+CHUNK-1:0] w_res_next;

        logic                r_v;
        logic                r_c;
        logic [LO+CHUNK-1:0] r_res;

        if (k == 0) begin : g_head
            assign w_a_in     = in1;
            assign w_b_in     = w_b_eff;
            assign w_c_in     = sub;
            assign w_v_in     = in_valid;
            assign w_res_next = w_s;
        end else begin : g_body
            assign w_a_in     = g_stage[k-1].g_fwd.r_a;
            assign w_b_in     = g_stage[k-1].g_fwd.r_b;
            assign w_c_in     = g_stage[k-1].r_c;
            assign w_v_in     = g_stage[k-1].r_v;
            assign w_res_next = {w_s, g_stage[k-1].r_res};
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (w_a_in[CHUNK-1:0]),
            .b    (w_b_in[CHUNK-1:0]),
            .cin  (w_c_in),
            .sum  (w_s),
            .cout (w_co)
        );

        // Stage valid, carry and accumulated result; all hold while stalled.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_res <= {(LO+CHUNK){1'b0}};
            end else if (w_en) begin
                r_v   <= w_v_in;
                r_c   <= w_co;
                r_res <= w_res_next;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [OPW-CHUNK-1:0] r_a;
            logic [OPW-CHUNK-1:0] r_b;

            // Skew delay of the operand chunks not yet added.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a <= {(OPW-CHUNK){1'b0}};
                    r_b <= {(OPW-CHUNK){1'b0}};
                end else if (w_en) begin
                    r_a <= w_a_in[OPW-1:CHUNK];
                    r_b <= w_b_in[OPW-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign out       = g_stage[STAGES-1].r_res;
    assign cout      = g_stage[STAGES-1].r_c;

`ifdef PIPE_ADDER_FLAGS_EN
    logic r_ovf;
    logic r_zero;

    // Flags are computed alongside the final chunk so they align with out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            r_ovf  <= signed_ovf(g_stage[STAGES-1].w_a_in[CHUNK-1],
                                 g_stage[STAGES-1].w_b_in[CHUNK-1],
                                 g_stage[STAGES-1].w_s[CHUNK-1]);
            r_zero <= (g_stage[STAGES-1].w_res_next == {WIDTH{1'b0}});
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=32, CHUNK=8, four stages).
`timescale 1ns/1ps
module tb_pipe_adder;

`ifdef PIPE_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = 32'h0;
    logic [31:0] in2 = 32'h0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_checks = 0;
    int n_err    = 0;

    pipe_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Issue one op into an idle pipe and wait (bounded) for its result.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r, output logic co, output logic ov,
                         output logic z, output int lat);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in1 = a; in2 = b; sub = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = out; co = cout; ov = ovf; z = zero;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out !== 32'h0) begin n_err++; $display("FAIL reset_out got=%h exp=0", out); end
        n_checks++; if ({cout, ovf, zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {cout, ovf, zero}); end
        n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        logic [31:0] r; logic co, ov, z; int lat;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, r, co, ov, z, lat);
        n_checks++; if (lat !== 4) begin n_err++; $display("FAIL add_latency got=%0d exp=4", lat); end
        n_checks++; if (r !== 32'h0000_0000) begin n_err++; $display("FAIL add_wrap_out got=%h exp=00000000", r); end
        n_checks++; if ({co, ov, z} !== {1'b1, 1'b0, FLAGS}) begin n_err++; $display("FAIL add_wrap_flags got=%b exp=%b", {co, ov, z}, {1'b1, 1'b0, FLAGS}); end
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, r, co, ov, z, lat);
        n_checks++; if ({co, r} !== {1'b0, 32'hACF1_3568}) begin n_err++; $display("FAIL add_mixed got=%b_%h exp=0_acf13568", co, r); end
        do_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, r, co, ov, z, lat);
        n_checks++; if ({co, r} !== {1'b0, 32'h0100_0100}) begin n_err++; $display("FAIL add_chunk_carry got=%b_%h exp=0_01000100", co, r); end
    endtask

    task automatic test_sub();
        logic [31:0] r; logic co, ov, z; int lat;
        do_op(32'd5, 32'd7, 1'b1, r, co, ov, z, lat);
        n_checks++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_5m7_out got=%h exp=fffffffe", r); end
        n_checks++; if ({co, ov, z} !== 3'b000) begin n_err++; $display("FAIL sub_5m7_flags got=%b exp=000", {co, ov, z}); end
        do_op(32'd7, 32'd5, 1'b1, r, co, ov, z, lat);
        n_checks++; if ({co, r} !== {1'b1, 32'h0000_0002}) begin n_err++; $display("FAIL sub_7m5 got=%b_%h exp=1_00000002", co, r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic co, ov, z; int lat;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, r, co, ov, z, lat);
        n_checks++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_add_out got=%h exp=80000000", r); end
        n_checks++; if ({co, ov, z} !== {1'b0, FLAGS, 1'b0}) begin n_err++; $display("FAIL ovf_add_flags got=%b exp=%b", {co, ov, z}, {1'b0, FLAGS, 1'b0}); end
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, r, co, ov, z, lat);
        n_checks++; if (r !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL ovf_sub_out got=%h exp=7fffffff", r); end
        n_checks++; if ({co, ov, z} !== {1'b1, FLAGS, 1'b0}) begin n_err++; $display("FAIL ovf_sub_flags got=%b exp=%b", {co, ov, z}, {1'b1, FLAGS, 1'b0}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_t [6];
        logic [31:0] b_t [6];
        logic [31:0] e_t [6];
        logic        s_t [6];
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic exp_ir;
        a_t = '{32'h0000_0010, 32'h0000_0100, 32'h0000_00FF, 32'h0001_0000, 32'h0000_FFFF, 32'hFFFF_FFFF};
        b_t = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
        s_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        e_t = '{32'h0000_0011, 32'h0000_00FF, 32'h0000_0100, 32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFE};
        @(posedge clk); #1;
        while (recv < 6 && cyc < 40) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (sent < 6) begin
                in_valid = 1'b1; in1 = a_t[sent]; in2 = b_t[sent]; sub = s_t[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc <= 9) begin
                exp_ir = !(cyc >= 5 && cyc <= 7);
                n_checks++; if (in_ready !== exp_ir) begin n_err++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ir); end
            end
            if (cyc >= 5 && cyc <= 7) begin
                n_checks++; if ({out_valid, out} !== {1'b1, e_t[1]}) begin n_err++; $display("FAIL b2b_stall_hold cyc=%0d got=%b_%h exp=1_%h", cyc, out_valid, out, e_t[1]); end
            end
            if (out_valid && out_ready) begin
                n_checks++; if (out !== e_t[recv]) begin n_err++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", recv, out, e_t[recv]); end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (recv !== 6) begin n_err++; $display("FAIL b2b_count got=%0d exp=6", recv); end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] r; logic co, ov, z; int lat;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in1 = 32'd3; in2 = 32'd4; sub = 1'b0;
        @(posedge clk); #1;
        in1 = 32'h10; in2 = 32'h1; sub = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if ({out_valid, out} !== {1'b1, 32'd7}) begin n_err++; $display("FAIL rst_pre_result got=%b_%h exp=1_00000007", out_valid, out); end
        #3;
        rst = 1'b0;
        #1;
        n_checks++; if ({out_valid, cout, out} !== {1'b0, 1'b0, 32'h0}) begin n_err++; $display("FAIL rst_async_clear got=%b_%b_%h exp=0_0_0", out_valid, cout, out); end
        n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        do_op(32'h20, 32'h22, 1'b0, r, co, ov, z, lat);
        n_checks++; if (lat !== 4) begin n_err++; $display("FAIL rst_first_latency got=%0d exp=4", lat); end
        n_checks++; if (r !== 32'h42) begin n_err++; $display("FAIL rst_first_result got=%h exp=00000042", r); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_back_to_back();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
